// File: rtl/glitch_sequencer.sv
// glitch_sequencer: runs the glitch program ROM (I2C byte checks, DAC loads, delays); ports clk/rst/arm, ROM instr_pt/instr, delay table delay_num/delay_len, sniffer sniff_*, DAC dac_*, status busy/done/fault; define GLITCH_SEQ_CHK_TIMEOUT_EN to enable the CHK_WAIT watchdog
module glitch_sequencer #(
  parameter int          PROG_LEN    = 17,
  parameter logic [31:0] CHK_TIMEOUT = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  output logic [7:0]  instr_pt,
  input  logic [11:0] instr,
  output logic [7:0]  delay_num,
  input  logic [31:0] delay_len,
  input  logic        sniff_valid,
  input  logic        sniff_bus,
  input  logic [7:0]  sniff_byte,
  input  logic        sniff_ack,
  output logic [7:0]  dac_data,
  output logic        dac_load,
  input  logic        dac_ready,
  output logic        busy,
  output logic        done,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, CHK_WAIT, DAC_WAIT, DLY_LOAD, DLY_RUN, DONE} state_t;
  localparam logic [7:0] LAST = 8'(PROG_LEN);
  state_t r_state, w_state;
  logic [11:0] r_ir, w_ir;
  logic [31:0] r_cnt, w_cnt;
  logic [7:0] r_chk_base, w_chk_base, w_instr_pt, w_delay_num, w_dac_data;
  logic r_last_chk, w_last_chk, w_dac_load, w_done, w_hit, w_match, w_to;
  assign w_hit = sniff_valid && sniff_bus == r_ir[9];
  assign w_match = sniff_byte == r_ir[8:1] && sniff_ack == r_ir[0];
  assign busy = r_state != IDLE && r_state != DONE;
  always_comb begin
    w_state = r_state;
    w_ir = r_ir;
    w_cnt = r_cnt;
    w_chk_base = r_chk_base;
    w_instr_pt = instr_pt;
    w_delay_num = delay_num;
    w_dac_data = dac_data;
    w_last_chk = r_last_chk;
    w_dac_load = 1'b0;
    w_done = done;
    case (r_state)
      IDLE, DONE: if (arm) begin
        w_state = FETCH;
        w_instr_pt = '0;
        w_chk_base = '0;
        w_last_chk = 1'b0;
        w_done = 1'b0;
      end
      FETCH: if (instr_pt >= LAST) begin
        w_state = DONE;
        w_done = 1'b1;
      end else begin
        w_ir = instr;
        w_state = EXEC;
      end
      EXEC: begin
        w_last_chk = r_ir[11:10] == 2'b00;
        case (r_ir[11:10])
          2'b00: begin
            w_state = CHK_WAIT;
            w_chk_base = r_last_chk ? r_chk_base : instr_pt;
          end
          2'b01: begin
            w_dac_data = r_ir[8:1];
            w_dac_load = dac_ready;
            w_instr_pt = dac_ready ? instr_pt + 8'd1 : instr_pt;
            w_state = dac_ready ? FETCH : DAC_WAIT;
          end
          2'b10: begin
            w_delay_num = r_ir[8:1];
            w_state = DLY_LOAD;
          end
          default: begin
            w_state = DONE;
            w_done = 1'b1;
          end
        endcase
      end
      CHK_WAIT: if (w_hit) begin
        w_state = FETCH;
        w_instr_pt = w_match ? instr_pt + 8'd1 : r_chk_base;
      end else if (w_to) begin
        w_state = DONE;
      end
      DAC_WAIT: if (dac_ready) begin
        w_dac_load = 1'b1;
        w_instr_pt = instr_pt + 8'd1;
        w_state = FETCH;
      end
      DLY_LOAD: begin
        w_cnt = delay_len;
        w_state = DLY_RUN;
      end
      DLY_RUN: if (r_cnt == '0) begin
        w_instr_pt = instr_pt + 8'd1;
        w_state = FETCH;
      end else begin
        w_cnt = r_cnt - 32'd1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ir <= '0;
      r_cnt <= '0;
      r_chk_base <= '0;
      r_last_chk <= 1'b0;
      instr_pt <= '0;
      delay_num <= '0;
      dac_data <= '0;
      dac_load <= 1'b0;
      done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ir <= w_ir;
      r_cnt <= w_cnt;
      r_chk_base <= w_chk_base;
      r_last_chk <= w_last_chk;
      instr_pt <= w_instr_pt;
      delay_num <= w_delay_num;
      dac_data <= w_dac_data;
      dac_load <= w_dac_load;
      done <= w_done;
    end
`ifdef GLITCH_SEQ_CHK_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic r_fault;
  assign w_to = r_wdog == CHK_TIMEOUT - 32'd1;
  assign fault = r_fault;
  always_ff @(posedge clk)
    if (rst) begin
      r_wdog <= '0;
      r_fault <= 1'b0;
    end else begin
      r_wdog <= (r_state != CHK_WAIT || w_hit) ? '0 : r_wdog + 32'd1;
      r_fault <= (r_state == CHK_WAIT && !w_hit && w_to) ? 1'b1 : (!busy && arm) ? 1'b0 : r_fault;
    end
`else
  assign w_to = 1'b0;
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: table vectors, corner-case sequences and a randomized program-level reference model for glitch_sequencer
module tb_glitch_sequencer;
  localparam int PL = 17;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b0, arm = 1'b0, sniff_valid = 1'b0, sniff_bus = 1'b0, sniff_ack = 1'b0, dac_ready = 1'b0;
  logic [7:0] sniff_byte = '0;
  logic [7:0] instr_pt, delay_num, dac_data;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic dac_load, busy, done, fault;
  logic [11:0] rom [256];
  logic [31:0] dtab [256];
  int n_cmp = 0, n_err = 0;
  assign instr = rom[instr_pt];
  assign delay_len = dtab[delay_num];
  always #5 clk = ~clk;
  glitch_sequencer #(.PROG_LEN(PL), .CHK_TIMEOUT(32'(TO))) dut (
    .clk(clk), .rst(rst), .arm(arm), .instr_pt(instr_pt), .instr(instr),
    .delay_num(delay_num), .delay_len(delay_len), .sniff_valid(sniff_valid),
    .sniff_bus(sniff_bus), .sniff_byte(sniff_byte), .sniff_ack(sniff_ack),
    .dac_data(dac_data), .dac_load(dac_load), .dac_ready(dac_ready),
    .busy(busy), .done(done), .fault(fault)
  );
  typedef struct {
    logic [11:0] ins;
    int          e2f;
    logic        ld;
    logic [7:0]  dac;
  } vec_t;
  vec_t tbl [6];
  int m_pc, m_left, m_blk, m_dcnt, m_base, m_wd;
  logic m_run, m_prev, m_done, m_fault, m_load;
  logic [7:0] m_dac, m_dnum;
  function automatic logic [11:0] enc(input logic [1:0] op, input logic b, input logic [7:0] d, input logic a);
    return {op, b, d, a};
  endfunction
  function automatic logic [11:0] rand_instr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return enc(2'b00, 1'b1, $urandom_range(0, 1) ? 8'h84 : 8'h01, 1'b0);
    if (r < 7) return enc(2'b01, 1'($urandom), 8'($urandom), 1'($urandom));
    if (r < 9) return enc(2'b10, 1'($urandom), 8'($urandom), 1'($urandom));
    return enc(2'b11, 1'($urandom), 8'($urandom), 1'($urandom));
  endfunction
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic send(input logic b, input logic [7:0] d, input logic a);
    sniff_valid = 1'b1;
    sniff_bus = b;
    sniff_byte = d;
    sniff_ack = a;
    tick();
    sniff_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(nm, 64'(done), 64'd1);
  endtask
  task automatic check_reset_vals(input string nm);
    check({nm, "_pt"}, 64'(instr_pt), 64'd0);
    check({nm, "_dnum"}, 64'(delay_num), 64'd0);
    check({nm, "_dac"}, 64'(dac_data), 64'd0);
    check({nm, "_load"}, 64'(dac_load), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_done"}, 64'(done), 64'd0);
    check({nm, "_fault"}, 64'(fault), 64'd0);
  endtask
  task automatic m_exec(input logic [11:0] ins);
    case (ins[11:10])
      2'b00: begin
        if (!m_prev) m_base = m_pc;
        m_blk = 1;
        m_wd = 0;
      end
      2'b01: begin
        m_dac = ins[8:1];
        if (dac_ready) begin
          m_load = 1'b1;
          m_pc++;
          m_left = 2;
        end else m_blk = 2;
      end
      2'b10: begin
        m_dnum = ins[8:1];
        m_dcnt = int'(dtab[ins[8:1]]) + 2;
        m_blk = 3;
      end
      default: begin
        m_run = 1'b0;
        m_done = 1'b1;
      end
    endcase
    m_prev = ins[11:10] == 2'b00;
  endtask
  task automatic model_step();
    logic [11:0] cur;
    m_load = 1'b0;
    if (rst) begin
      m_run = 0; m_pc = 0; m_dnum = 0; m_dac = 0; m_done = 0; m_fault = 0;
      m_left = 0; m_blk = 0; m_base = 0; m_prev = 0; m_wd = 0;
    end else if (!m_run) begin
      if (arm) begin
        m_run = 1; m_pc = 0; m_base = 0; m_prev = 0; m_done = 0; m_fault = 0;
        m_left = 2; m_blk = 0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1 && m_pc >= PL) begin
        m_run = 0;
        m_done = 1;
        m_left = 0;
      end else if (m_left == 0) m_exec(rom[m_pc]);
    end else begin
      cur = rom[m_pc];
      if (m_blk == 1) begin
        if (sniff_valid && sniff_bus == cur[9]) begin
          m_pc = (sniff_byte == cur[8:1] && sniff_ack == cur[0]) ? m_pc + 1 : m_base;
          m_left = 2;
          m_blk = 0;
        end else begin
          m_wd++;
`ifdef GLITCH_SEQ_CHK_TIMEOUT_EN
          if (m_wd == TO) begin
            m_run = 0;
            m_fault = 1;
            m_blk = 0;
          end
`endif
        end
      end else if (m_blk == 2) begin
        if (dac_ready) begin
          m_load = 1;
          m_pc++;
          m_left = 2;
          m_blk = 0;
        end
      end else if (m_blk == 3) begin
        m_dcnt--;
        if (m_dcnt == 0) begin
          m_pc++;
          m_left = 2;
          m_blk = 0;
        end
      end
    end
  endtask
  initial begin
    int n, loads;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 12'hC00;
      dtab[i] = 32'd0;
    end
    dtab[3] = 32'h1B;
    dtab[5] = 32'd1;
    dtab[7] = 32'd12;
    tbl[0] = '{enc(2'b10, 1'b0, 8'd3, 1'b0), 30, 1'b0, 8'h00};
    tbl[1] = '{enc(2'b10, 1'b0, 8'd0, 1'b0), 3, 1'b0, 8'h00};
    tbl[2] = '{enc(2'b10, 1'b1, 8'd5, 1'b1), 4, 1'b0, 8'h00};
    tbl[3] = '{enc(2'b10, 1'b0, 8'd7, 1'b0), 15, 1'b0, 8'h00};
    tbl[4] = '{enc(2'b01, 1'b0, 8'h5A, 1'b0), 1, 1'b1, 8'h5A};
    tbl[5] = '{enc(2'b01, 1'b1, 8'hC3, 1'b1), 1, 1'b1, 8'hC3};
    do_reset();
    check_reset_vals("reset");
    for (int t = 0; t < 6; t++) begin
      do_reset();
      rom[0] = tbl[t].ins;
      rom[1] = 12'hC00;
      dac_ready = 1'b1;
      do_arm();
      n = 0;
      while (instr_pt != 8'd1 && n < 200) begin
        tick();
        n++;
      end
      check($sformatf("tbl%0d_exec2fetch", t), 64'(n - 1), 64'(tbl[t].e2f));
      check($sformatf("tbl%0d_load", t), 64'(dac_load), 64'(tbl[t].ld));
      wait_done(20, $sformatf("tbl%0d_done", t));
      check($sformatf("tbl%0d_busy", t), 64'(busy), 64'd0);
      check($sformatf("tbl%0d_dac", t), 64'(dac_data), 64'(tbl[t].dac));
    end
    do_reset();
    rom[0] = enc(2'b00, 1'b1, 8'h84, 1'b0);
    rom[1] = enc(2'b00, 1'b1, 8'h01, 1'b0);
    rom[2] = enc(2'b00, 1'b1, 8'h0F, 1'b0);
    rom[3] = 12'hC00;
    do_arm();
    idle(3); send(1'b1, 8'h84, 1'b0);
    check("chk_first", 64'(instr_pt), 64'd1);
    idle(3); send(1'b1, 8'h01, 1'b0);
    check("chk_second", 64'(instr_pt), 64'd2);
    idle(3); send(1'b1, 8'h0F, 1'b0);
    check("chk_third", 64'(instr_pt), 64'd3);
    wait_done(10, "chk_done");
    do_arm();
    idle(3); send(1'b1, 8'h84, 1'b0);
    check("rw_first", 64'(instr_pt), 64'd1);
    send(1'b1, 8'h01, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    idle(3);
    check("drop_outside_wait", 64'(instr_pt), 64'd1);
    send(1'b1, 8'h02, 1'b0);
    check("chk_rewind", 64'(instr_pt), 64'd0);
    idle(3); send(1'b0, 8'h84, 1'b0);
    check("bus0_ignored", 64'(instr_pt), 64'd0);
    send(1'b1, 8'h84, 1'b0);
    idle(3); send(1'b0, 8'h01, 1'b0);
    check("bus0_ignored2", 64'(instr_pt), 64'd1);
    send(1'b1, 8'h01, 1'b0);
    idle(3); send(1'b0, 8'h0F, 1'b1);
    send(1'b1, 8'h0F, 1'b0);
    check("rw_reach3", 64'(instr_pt), 64'd3);
    wait_done(10, "rw_done");
    do_reset();
    rom[0] = enc(2'b01, 1'b0, 8'h8E, 1'b0);
    rom[1] = 12'hC00;
    dac_ready = 1'b0;
    do_arm();
    loads = 0;
    repeat (7) begin
      tick();
      loads += int'(dac_load);
    end
    check("dac_no_load_while_busy", 64'(loads), 64'd0);
    check("dac_data_early", 64'(dac_data), 64'h8E);
    dac_ready = 1'b1;
    tick();
    check("dac_load_pulse", 64'(dac_load), 64'd1);
    check("dac_load_data", 64'(dac_data), 64'h8E);
    loads = 0;
    repeat (6) begin
      tick();
      loads += int'(dac_load);
    end
    check("dac_single_pulse", 64'(loads), 64'd0);
    check("dac_done", 64'(done), 64'd1);
    check("dac_after_done", 64'(dac_data), 64'h8E);
    do_reset();
    for (int i = 0; i < PL; i++) rom[i] = enc(2'b01, 1'b0, 8'(i + 32'h20), 1'b0);
    dac_ready = 1'b1;
    do_arm();
    wait_done(100, "end_done");
    check("end_busy", 64'(busy), 64'd0);
    check("end_pt", 64'(instr_pt), 64'(PL));
    check("end_dac", 64'(dac_data), 64'h30);
    do_arm();
    check("rearm_pt", 64'(instr_pt), 64'd0);
    check("rearm_busy", 64'(busy), 64'd1);
    check("rearm_done", 64'(done), 64'd0);
    do_reset();
    rom[0] = enc(2'b01, 1'b0, 8'h77, 1'b0);
    rom[1] = enc(2'b10, 1'b0, 8'd3, 1'b0);
    rom[2] = 12'hC00;
    do_arm();
    idle(10);
    check("mid_dly_busy", 64'(busy), 64'd1);
    check("mid_dly_dnum", 64'(delay_num), 64'd3);
    do_reset();
    check_reset_vals("midrst");
    idle(3);
    check("midrst_stays_idle", 64'(busy), 64'd0);
`ifdef GLITCH_SEQ_CHK_TIMEOUT_EN
    do_reset();
    rom[0] = enc(2'b00, 1'b1, 8'h84, 1'b0);
    do_arm();
    n = 0;
    while (!fault && n < 200) begin
      tick();
      n++;
    end
    check("wdog_cycles", 64'(n - 2), 64'(TO));
    check("wdog_done", 64'(done), 64'd0);
    check("wdog_busy", 64'(busy), 64'd0);
`endif
    for (int i = 0; i < 256; i++) dtab[i] = 32'($urandom_range(0, 6));
    for (int p = 0; p < 8; p++) begin
      rst = 1'b1;
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      for (int c = 0; c < 600; c++) begin
        rst = c == 0 || $urandom_range(0, 499) == 0;
        arm = c == 1 || $urandom_range(0, 19) == 0;
        dac_ready = $urandom_range(0, 3) != 0;
        sniff_valid = $urandom_range(0, 2) == 0;
        sniff_bus = $urandom_range(0, 4) != 0;
        sniff_byte = $urandom_range(0, 1) ? 8'h84 : 8'h01;
        sniff_ack = $urandom_range(0, 9) == 0;
        @(posedge clk);
        model_step();
        #1;
        check($sformatf("rand_p%0d_c%0d", p, c),
              64'({instr_pt, delay_num, dac_data, dac_load, busy, done, fault}),
              64'({8'(m_pc), m_dnum, m_dac, m_load, m_run, m_done, m_fault}));
      end
    end
    rst = 1'b0;
    arm = 1'b0;
    sniff_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Executes the glitch program stored in the program ROM. It walks `instr_pt` through the ROM and decodes each 12-bit instruction. It then waits for a matching I2C byte from the bus sniffer, loads a DAC code, or counts a delay looked up through `delay_num`/`delay_len`. It sits between the ROM, the I2C sniffer front end, and the DAC interface, and is the sole consumer of the ROM's outputs.

## Interface
- `PROG_LEN`, 17: number of valid ROM entries; reaching this `instr_pt` ends the program.
- `CHK_TIMEOUT`, 32'd100000000: I2C_CHK watchdog in cycles. Used only with `GLITCH_SEQ_CHK_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: start pulse, sampled only in IDLE or DONE.
- `instr_pt` out 8: ROM address.
- `instr` in 12: ROM data, combinational from `instr_pt`.
- `delay_num` out 8: delay table index.
- `delay_len` in 32: delay table data, combinational from `delay_num`.
- `sniff_valid` in 1: one-cycle strobe, one per observed I2C byte.
- `sniff_bus` in 1: bus of that byte (1 = private, 0 = main).
- `sniff_byte` in 8: byte value.
- `sniff_ack` in 1: ACK bit following the byte (0 = ACK, 1 = NAK).
- `dac_data` out 8: DAC code.
- `dac_load` out 1: one-cycle write strobe.
- `dac_ready` in 1: DAC interface can accept a write.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: program completed normally.
- `fault` out 1: program aborted by the watchdog.

## Operation
- Instruction fields:
  - [11:10] opcode: 00 I2C_CHK, 01 DAC_UP, 10 DELAY, 11 END.
  - [9] bus select.
  - [8:1] data.
  - [0] expected ACK.
- The instruction register `ir` captures `instr` in FETCH. `instr_pt` is registered.
- States: IDLE, FETCH, EXEC, CHK_WAIT, DAC_WAIT, DLY_LOAD, DLY_RUN, DONE.
- IDLE/DONE + `arm`: `instr_pt`←0, `chk_base`←0, clear `done`/`fault`, go to FETCH.
- FETCH:
  - If `instr_pt` ≥ `PROG_LEN`, go to DONE.
  - Otherwise `ir`←`instr` and go to EXEC.
- EXEC by opcode:
  - END: go to DONE.
  - I2C_CHK: go to CHK_WAIT. If the previous executed instruction was not I2C_CHK, `chk_base`←`instr_pt`.
  - DAC_UP: `dac_data`←data. If `dac_ready`, pulse `dac_load`, advance, go to FETCH. Otherwise go to DAC_WAIT.
  - DELAY: `delay_num`←data, go to DLY_LOAD.
- CHK_WAIT, on `sniff_valid` with `sniff_bus` == ir[9]:
  - Byte and ACK both equal ir[8:1] and ir[0]: advance and go to FETCH.
  - Either differs: `instr_pt`←`chk_base`, go to FETCH. This rewinds to the first instruction of the current contiguous I2C_CHK run, so that run matches only consecutive bytes.
  - Bytes on the other bus are ignored.
- DAC_WAIT: on the first cycle `dac_ready`=1, pulse `dac_load`, advance, go to FETCH.
- DLY_LOAD: `cnt`←`delay_len` (32-bit), go to DLY_RUN.
- DLY_RUN: if `cnt`==0, advance and go to FETCH; otherwise `cnt`←`cnt`−1.
- "Advance" means `instr_pt`←`instr_pt`+1, 8-bit. It cannot wrap in practice because `PROG_LEN` ≤ 255 ends the program first.
- `dac_data` holds its last value in DONE and IDLE. Only reset clears it.

## Timing
- Reset values: `instr_pt`=0, `delay_num`=0, `dac_data`=0, `dac_load`=0, `busy`=0, `done`=0, `fault`=0. State is IDLE, `cnt`=0, `chk_base`=0.
- Reset asserted mid-operation returns to IDLE on the next edge. No `dac_load` pulse is issued on that edge.
- `arm` at edge t: FETCH at t+1, EXEC at t+2.
- FETCH and EXEC take one cycle each.
- DAC_UP with `dac_ready` high: `dac_load` asserts in the cycle after EXEC, together with the new `dac_data`, for exactly one cycle.
- DELAY occupies EXEC + DLY_LOAD + (`delay_len`+1) DLY_RUN cycles.
- A matching `sniff_valid` in CHK_WAIT at edge t gives FETCH at t+1.
- `sniff_valid` arriving in any state other than CHK_WAIT is dropped, not queued.
- `arm` while `busy` is ignored.

## Configuration
- `GLITCH_SEQ_CHK_TIMEOUT_EN` defined:
  - A 32-bit watchdog clears on entry to CHK_WAIT and on every `sniff_valid` on the selected bus.
  - When it reaches `CHK_TIMEOUT`, the block sets `fault`=1 and goes to DONE with `done`=0.
- Undefined: CHK_WAIT waits indefinitely, and `fault` is tied to 0.

## Test plan
- ROM holds I2C_CHK 0x84, 0x01, 0x0F (bus 1, ACK) at entries 0–2. Feed those bytes on bus 1 -> `instr_pt` reaches 3 one cycle after the third strobe.
- Feed 0x84 then 0x02 on bus 1 -> `instr_pt` returns to 0. Then 0x84, 0x01, 0x0F -> reaches 3. Interleaved bytes on bus 0 change nothing.
- DELAY with `delay_num`=3 (`delay_len`=0x1B) -> exactly 30 cycles from EXEC to the next FETCH. With `delay_len`=0 -> 3 cycles.
- DAC_UP 0x8E with `dac_ready` low for 5 cycles -> a single `dac_load` on the first ready cycle with `dac_data`=0x8E. `dac_data` still reads 0x8E after `done`.
- Program reaches `instr_pt`=`PROG_LEN` -> `done`=1, `busy`=0. A subsequent `arm` restarts at 0. `rst` pulsed mid-DLY_RUN -> IDLE next cycle with all reset values.
- With `GLITCH_SEQ_CHK_TIMEOUT_EN` and `CHK_TIMEOUT`=50, no sniffer traffic -> `fault`=1 in DONE 50 cycles after CHK_WAIT entry.
